// File: rtl/uart_bus_master.sv
// uart_bus_master: UART 8N1 command decoder driving a 32-bit bus; optional frame timeout via UART_BUS_MASTER_TIMEOUT_EN
module uart_bus_master #(
  parameter int BAUD_RATE   = 115200,
  parameter int CLK_VAL_MHZ = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic        enable,
  output logic        r_w,
  output logic [3:0]  byte_EN,
  output logic [31:0] dataout,
  output logic [31:0] addressout,
  input  logic [31:0] datain,
  output logic        busy
);
  localparam int CPB = (CLK_VAL_MHZ * 1000000) / BAUD_RATE;
  localparam int CW = $clog2(CPB + 1);
  localparam logic [CW-1:0] CPB_M1 = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, RD_CAP, SEND} state_t;
  rx_state_t r_state;
  state_t state;
  logic rx_s1, rx_s2, rx_prev, rx_valid;
  logic [CW-1:0] r_cnt, t_cnt;
  logic [2:0] r_bit;
  logic [7:0] rx_sr, tx_byte;
  logic [9:0] tx_sr;
  logic [3:0] t_bit;
  logic t_busy, tx_done, tx_go, cmd_rd;
  logic [1:0] b_cnt, s_last;
  logic [31:0] resp;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
  localparam logic [31:0] TO_M1 = 32'(16 * CPB - 1);
  logic [31:0] to_cnt;
`endif
  assign busy = state != IDLE;
  // RX: synchronise, find start edge, confirm at half bit, sample bit centres, validate stop
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_prev <= 1'b1;
      r_state <= R_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      rx_sr <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_prev <= rx_s2;
      rx_valid <= 1'b0;
      case (r_state)
        R_IDLE: if (rx_prev && !rx_s2) begin
          r_state <= R_START;
          r_cnt <= '0;
        end
        R_START: if (r_cnt != HALF_M1) r_cnt <= r_cnt + 1'b1;
        else begin
          r_cnt <= '0;
          r_bit <= '0;
          r_state <= rx_s2 ? R_IDLE : R_DATA;
        end
        R_DATA: if (r_cnt != CPB_M1) r_cnt <= r_cnt + 1'b1;
        else begin
          r_cnt <= '0;
          rx_sr <= {rx_s2, rx_sr[7:1]};
          r_bit <= r_bit + 1'b1;
          if (r_bit == 3'd7) r_state <= R_STOP;
        end
        default: if (r_cnt != CPB_M1) r_cnt <= r_cnt + 1'b1;
        else begin
          r_cnt <= '0;
          r_state <= R_IDLE;
          rx_valid <= rx_s2;
        end
      endcase
    end
  // TX: shift out start, 8 data bits LSB first and stop, pulse tx_done at end of stop bit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx <= 1'b1;
      t_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_sr <= '0;
      t_cnt <= '0;
      t_bit <= '0;
    end else begin
      tx_done <= 1'b0;
      if (!t_busy) begin
        if (tx_go) begin
          tx_sr <= {1'b1, tx_byte, 1'b0};
          t_busy <= 1'b1;
          t_cnt <= '0;
          t_bit <= '0;
          tx <= 1'b0;
        end
      end else if (t_cnt != CPB_M1) t_cnt <= t_cnt + 1'b1;
      else begin
        t_cnt <= '0;
        tx_sr <= {1'b1, tx_sr[9:1]};
        tx <= tx_sr[1];
        t_bit <= t_bit + 1'b1;
        if (t_bit == 4'd9) begin
          t_busy <= 1'b0;
          tx_done <= 1'b1;
          tx <= 1'b1;
        end
      end
    end
  // Command FSM: collect frame bytes, issue one-cycle bus strobe, queue the response bytes
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cmd_rd <= 1'b0;
      b_cnt <= '0;
      s_last <= '0;
      enable <= 1'b0;
      r_w <= 1'b0;
      byte_EN <= '0;
      dataout <= '0;
      addressout <= '0;
      resp <= '0;
      tx_go <= 1'b0;
      tx_byte <= '0;
`ifdef UART_BUS_MASTER_TIMEOUT_EN
      to_cnt <= '0;
`endif
    end else begin
      tx_go <= 1'b0;
      case (state)
        IDLE: if (rx_valid) begin
          b_cnt <= '0;
          if (rx_sr == 8'h57 || rx_sr == 8'h52) begin
            cmd_rd <= rx_sr == 8'h52;
            state <= GET_ADDR;
          end else begin
            tx_byte <= 8'h15;
            tx_go <= 1'b1;
            s_last <= '0;
            state <= SEND;
          end
        end
        GET_ADDR: if (rx_valid) begin
          addressout <= {addressout[23:0], rx_sr};
          b_cnt <= b_cnt + 2'd1;
          if (b_cnt == 2'd3) begin
            state <= cmd_rd ? BUS_RD : GET_DATA;
            enable <= cmd_rd;
            r_w <= cmd_rd;
            byte_EN <= cmd_rd ? 4'hF : 4'h0;
          end
        end
        GET_DATA: if (rx_valid) begin
          dataout <= {dataout[23:0], rx_sr};
          b_cnt <= b_cnt + 2'd1;
          if (b_cnt == 2'd3) begin
            state <= BUS_WR;
            enable <= 1'b1;
            r_w <= 1'b0;
            byte_EN <= 4'hF;
          end
        end
        BUS_WR: begin
          enable <= 1'b0;
          byte_EN <= '0;
          tx_byte <= 8'h06;
          tx_go <= 1'b1;
          s_last <= '0;
          b_cnt <= '0;
          state <= SEND;
        end
        BUS_RD: begin
          enable <= 1'b0;
          byte_EN <= '0;
          r_w <= 1'b0;
          state <= RD_CAP;
        end
        RD_CAP: begin
          tx_byte <= datain[31:24];
          resp <= {datain[23:0], 8'h00};
          tx_go <= 1'b1;
          s_last <= 2'd3;
          b_cnt <= '0;
          state <= SEND;
        end
        default: if (tx_done) begin
          if (b_cnt == s_last) state <= IDLE;
          else begin
            b_cnt <= b_cnt + 2'd1;
            tx_byte <= resp[31:24];
            resp <= {resp[23:0], 8'h00};
            tx_go <= 1'b1;
          end
        end
      endcase
`ifdef UART_BUS_MASTER_TIMEOUT_EN
      to_cnt <= (rx_valid || !(state == GET_ADDR || state == GET_DATA)) ? '0 : to_cnt + 32'd1;
      if ((state == GET_ADDR || state == GET_DATA) && !rx_valid && to_cnt == TO_M1) state <= IDLE;
`endif
    end
endmodule
